register_write_arbiter: RTL and testbench
=========================================

// Module: register_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of one DATA_WIDTH-bit FDCE-based register
//  between NUM_REQ requesters (e.g. ALU, bus loader, PC incrementer).
//  Drives the register's D, clock-enable and clear pins and acknowledges each requester.
//  Supports multi-cycle locked bursts, bounded by MAX_LOCK to prevent starvation.
// PARAMETERS
//  NUM_REQ     4  number of requesters (2..8)
//  DATA_WIDTH  8  register width
//  MAX_LOCK    4  max consecutive grant cycles while locked (>=1)
// PORTS
//  clock             in   1                   system clock, rising edge
//  input_reset_n     in   1                   synchronous, active-low reset
//  input_req         in   NUM_REQ             per-requester write request
//  input_clear_req   in   NUM_REQ             per-requester clear request (qualified by input_req)
//  input_lock        in   NUM_REQ             keep grant on following cycles (burst)
//  input_data        in   NUM_REQ*DATA_WIDTH  write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  output_grant      out  NUM_REQ             one-hot (or zero) current owner
//  output_ack        out  NUM_REQ             one-cycle pulse per accepted write or clear
//  output_d          out  DATA_WIDTH          to register D
//  output_clock_enable out 1                  to register CE
//  output_clear      out  1                   to register CLR
//  output_busy       out  1                   high in GRANT or LOCKED
// BEHAVIOUR
//  Reset (input_reset_n==0 at rising edge): all outputs 0, state IDLE, priority pointer 0,
//   lock counter 0. Reset overrides everything, including a burst in progress.
//  All outputs are registered. Request sampled at edge N -> grant/ack/CE/D at N+1 (latency 1).
//   The register captures output_d on the edge that ends cycle N+1.
//  Arbitration: first asserted input_req at or after the pointer, wrapping modulo NUM_REQ.
//   After granting i, the pointer becomes (i+1) mod NUM_REQ. The pointer does not move
//   while LOCKED.
//  Per granted cycle for owner i:
//   - input_clear_req[i]=1: output_clear=1, output_clock_enable=0, output_d=0.
//   - else: output_clock_enable=1, output_clear=0, output_d=input_data slice i
//     (sampled at the same edge as the request).
//   - output_ack[i]=1.
//  Idle cycles: output_clock_enable=0, output_clear=0, output_d holds its last value,
//   output_grant=0, output_ack=0.
//  States:
//   IDLE   -> GRANT on any request; stay in IDLE otherwise.
//   GRANT  -> LOCKED if owner's input_lock=1 and input_req=1 at the next edge;
//             else GRANT to the next round-robin winner if any request; else IDLE.
//   LOCKED -> owner re-granted each cycle; lock counter increments per granted cycle.
//             Exit when the owner drops input_req or input_lock, or the counter reaches
//             MAX_LOCK (forced release). On exit, re-arbitrate from the pointer; the
//             released owner has lowest priority. Counter clears on exit.
//  Total burst length including the first GRANT cycle is MAX_LOCK+1 cycles max.
//  Simultaneous input_lock from a non-owner is ignored. Dropping input_req in LOCKED:
//   no ack that cycle; ownership released the same edge.
//  output_grant is never multi-hot. output_clock_enable and output_clear are never both 1.
//  output_busy = (state != IDLE).
// TESTING
//  1 Reset: hold input_reset_n=0 with all req=1 -> all outputs 0 for every reset cycle.
//  2 Single write: req=4'b0010, data[15:8]=8'hA5 -> next cycle grant=0010, ack=0010,
//    CE=1, output_d=8'hA5; register reads A5 one edge later.
//  3 Round robin: req=4'b1111 held for 8 cycles -> grant order 0001,0010,0100,1000,
//    0001,...; one ack per cycle.
//  4 Clear: requester 2 with clear_req=1 -> clear=1, CE=0, ack=0100; register reads 0.
//  5 Lock limit: MAX_LOCK=4; requester 0 holds req+lock while req=1111 ->
//    5 consecutive grants to 0001, then 0010; requester 0 is not re-granted before 1000.
//  6 Reset mid-burst: drop input_reset_n during LOCKED cycle 2 -> outputs 0 next edge;
//    after release, first grant goes to the lowest-index requester (pointer 0).

Source files
------------

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing the write port (D/CE/CLR) of one register between
// NUM_REQ requesters, with locked bursts bounded by MAX_LOCK extra cycles.
module register_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 4
) (
    input  logic                          clock,
    input  logic                          input_reset_n,
    input  logic [NUM_REQ-1:0]            input_req,
    input  logic [NUM_REQ-1:0]            input_clear_req,
    input  logic [NUM_REQ-1:0]            input_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] input_data,
    output logic [NUM_REQ-1:0]            output_grant,
    output logic [NUM_REQ-1:0]            output_ack,
    output logic [DATA_WIDTH-1:0]         output_d,
    output logic                          output_clock_enable,
    output logic                          output_clear,
    output logic                          output_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_r, state_n;
    logic [PTR_W-1:0]     owner_r, owner_n;
    logic [PTR_W-1:0]     ptr_r, ptr_n;
    logic [CNT_W-1:0]     lock_cnt_r, lock_cnt_n;
    logic [NUM_REQ-1:0]   grant_r, grant_n;
    logic [NUM_REQ-1:0]   ack_r, ack_n;
    logic [DATA_WIDTH-1:0] d_r, d_n;
    logic                 ce_r, ce_n;
    logic                 clr_r, clr_n;
    logic                 busy_r, busy_n;

    logic [SUM_W-1:0]     cand_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic                 win_found_s;
    logic [SUM_W-1:0]     win_inc_s;
    logic [PTR_W-1:0]     ptr_after_win_s;
    logic                 keep_s;
    logic                 give_s;
    logic [PTR_W-1:0]     sel_s;

    assign win_found_s     = |input_req;
    assign win_inc_s       = {1'b0, win_idx_s} + SUM_W'(1);
    assign ptr_after_win_s = (win_inc_s >= SUM_W'(NUM_REQ)) ? '0 : win_inc_s[PTR_W-1:0];

    // The current owner keeps the port only while it still asks for it and the burst limit is not hit.
    assign keep_s = input_req[owner_r] && input_lock[owner_r] &&
                    ((state_r == ST_GRANT) ||
                     ((state_r == ST_LOCKED) && (lock_cnt_r < CNT_W'(MAX_LOCK))));

    // Round-robin search; scanning offsets high to low lets the smallest offset from the pointer win.
    always_comb begin
        win_idx_s = '0;
        cand_s    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s    = {1'b0, ptr_r} + SUM_W'(k);
            cand_s    = (cand_s >= SUM_W'(NUM_REQ)) ? (cand_s - SUM_W'(NUM_REQ)) : cand_s;
            win_idx_s = input_req[cand_s[PTR_W-1:0]] ? cand_s[PTR_W-1:0] : win_idx_s;
        end
    end

    // Next state, ownership and next registered outputs.
    always_comb begin
        state_n    = state_r;
        owner_n    = owner_r;
        ptr_n      = ptr_r;
        lock_cnt_n = '0;
        grant_n    = '0;
        ack_n      = '0;
        d_n        = d_r;
        ce_n       = 1'b0;
        clr_n      = 1'b0;
        give_s     = 1'b0;
        sel_s      = owner_r;

        case (state_r)
            ST_IDLE, ST_GRANT, ST_LOCKED: begin
                if ((state_r != ST_IDLE) && keep_s) begin
                    state_n    = ST_LOCKED;
                    lock_cnt_n = lock_cnt_r + CNT_W'(1);
                    give_s     = 1'b1;
                    sel_s      = owner_r;
                end else if (win_found_s) begin
                    state_n = ST_GRANT;
                    ptr_n   = ptr_after_win_s;
                    give_s  = 1'b1;
                    sel_s   = win_idx_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (give_s) begin
            owner_n = sel_s;
            grant_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
            ack_n   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
            if (input_clear_req[sel_s]) begin
                clr_n = 1'b1;
                d_n   = '0;
            end else begin
                ce_n = 1'b1;
                d_n  = input_data[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            owner_n = owner_r;
        end

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!input_reset_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            ptr_r      <= '0;
            lock_cnt_r <= '0;
            grant_r    <= '0;
            ack_r      <= '0;
            d_r        <= '0;
            ce_r       <= 1'b0;
            clr_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            owner_r    <= owner_n;
            ptr_r      <= ptr_n;
            lock_cnt_r <= lock_cnt_n;
            grant_r    <= grant_n;
            ack_r      <= ack_n;
            d_r        <= d_n;
            ce_r       <= ce_n;
            clr_r      <= clr_n;
            busy_r     <= busy_n;
        end
    end

    assign output_grant        = grant_r;
    assign output_ack          = ack_r;
    assign output_d            = d_r;
    assign output_clock_enable = ce_r;
    assign output_clear        = clr_r;
    assign output_busy         = busy_r;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed and randomized checks of register_write_arbiter against a burst-length
// based reference model; a behavioural FDCE register sits on the write port.
module tb_register_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_LOCK   = 4;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [3:0]  req, clr_req, lock;
    logic [31:0] data;

    logic [3:0]  dut_grant, dut_ack;
    logic [7:0]  dut_d;
    logic        dut_ce, dut_clr, dut_busy;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_burst = 0;
    logic [3:0] e_grant = 4'd0;
    logic [3:0] e_ack   = 4'd0;
    logic [7:0] e_d     = 8'd0;
    logic       e_ce    = 1'b0;
    logic       e_clr   = 1'b0;
    logic       e_busy  = 1'b0;
    logic [7:0] m_reg   = 8'd0;
    logic [7:0] fdce_q  = 8'd0;

    always #5 clock = ~clock;

    register_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_LOCK  (MAX_LOCK)
    ) dut (
        .clock              (clock),
        .input_reset_n      (rst_n),
        .input_req          (req),
        .input_clear_req    (clr_req),
        .input_lock         (lock),
        .input_data         (data),
        .output_grant       (dut_grant),
        .output_ack         (dut_ack),
        .output_d           (dut_d),
        .output_clock_enable(dut_ce),
        .output_clear       (dut_clr),
        .output_busy        (dut_busy)
    );

    // The register being written: clear has priority, then clock enable.
    always @(posedge clock) begin
        if (dut_clr) fdce_q <= 8'd0;
        else if (dut_ce) fdce_q <= dut_d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the reference model, using the inputs sampled at that edge.
    task automatic model_edge();
        int win;
        int idx;
        if (e_clr) m_reg = 8'd0;
        else if (e_ce) m_reg = e_d;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_burst = 0;
            e_grant = 4'd0; e_ack = 4'd0; e_d = 8'd0;
            e_ce = 1'b0; e_clr = 1'b0; e_busy = 1'b0;
        end else begin
            win = -1;
            if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_burst <= MAX_LOCK) begin
                win = m_owner;
                m_burst++;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && req[idx]) win = idx;
                end
                if (win >= 0) begin
                    m_ptr   = (win + 1) % NUM_REQ;
                    m_burst = 1;
                end else begin
                    m_burst = 0;
                end
            end
            m_owner = win;
            if (win >= 0) begin
                e_grant = 4'd1 << win;
                e_ack   = 4'd1 << win;
                e_busy  = 1'b1;
                e_clr   = clr_req[win];
                e_ce    = !clr_req[win];
                e_d     = clr_req[win] ? 8'd0 : data[win*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                e_grant = 4'd0; e_ack = 4'd0; e_busy = 1'b0;
                e_clr = 1'b0; e_ce = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("grant", dut_grant, e_grant);
        check("ack",   dut_ack,   e_ack);
        check("d",     dut_d,     e_d);
        check("ce",    dut_ce,    e_ce);
        check("clear", dut_clr,   e_clr);
        check("busy",  dut_busy,  e_busy);
        check("reg",   fdce_q,    m_reg);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; clr_req = 4'd0; lock = 4'b1111; data = 32'h0;

        // reset held with every request active
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_grant", dut_grant, 32'h0);
            check("rst_busy",  dut_busy,  32'h0);
        end

        // single write from requester 1
        rst_n = 1'b1; req = 4'b0010; lock = 4'd0; data = 32'h3C_7E_A5_11;
        step();
        check("single_grant", dut_grant, 32'h2);
        check("single_d",     dut_d,     32'hA5);
        check("single_ce",    dut_ce,    32'h1);
        req = 4'd0;
        step();
        check("single_reg", fdce_q, 32'hA5);

        // round robin from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_grant", dut_grant, 32'h1 << (i % 4));
        end

        // clear from requester 2
        req = 4'b0100; clr_req = 4'b0100;
        step();
        check("clr_clear", dut_clr, 32'h1);
        check("clr_ce",    dut_ce,  32'h0);
        check("clr_ack",   dut_ack, 32'h4);
        req = 4'd0; clr_req = 4'd0;
        step();
        check("clr_reg", fdce_q, 32'h0);

        // lock limit: 5 grants to requester 0, then rotation continues past it
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b1111; lock = 4'b0001; data = 32'h44_33_22_11;
        for (int i = 0; i < 5; i++) begin
            step();
            check("lock_hold", dut_grant, 32'h1);
        end
        step(); check("lock_rel1", dut_grant, 32'h2);
        step(); check("lock_rel2", dut_grant, 32'h4);
        step(); check("lock_rel3", dut_grant, 32'h8);
        step();

        // reset in the middle of a burst
        req = 4'b0001; lock = 4'b0001;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("midrst_grant", dut_grant, 32'h0);
        rst_n = 1'b1; req = 4'b1111; lock = 4'd0;
        step();
        check("midrst_first", dut_grant, 32'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            req     = 4'($urandom);
            clr_req = 4'($urandom & $urandom);
            lock    = 4'($urandom | $urandom);
            data    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
